// File: rtl/cp0_regs.sv
// cp0_regs: MIPS coprocessor-0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
// Commits exception state from the MEM-stage exception unit, services MTC0/MFC0,
// and runs the Count/Compare timer.
// Optional feature macro: CP0_TIMER_EN (Count/Compare/TI present when defined).
`timescale 1ns/1ps
module cp0_regs (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [31:0] except_type,
    input  logic [31:0] pcM,
    input  logic        is_in_delayslotM,
    input  logic [31:0] badvaddrM,
    input  logic [5:0]  int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    // Exception type encodings driven by the exception-detection unit
    localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
    localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        ti_q, ti_d;

    logic        exc_commit, is_eret, exc_addr;
    logic [4:0]  exc_code;

    // Decode the prioritised exception type into commit/ERET flags and ExcCode
    always_comb begin
        exc_code = '0;
        exc_addr = 1'b0;
        case (except_type)
            EXC_TYPE_INT:  exc_code = 5'h00;
            EXC_TYPE_ADEL: begin exc_code = 5'h04; exc_addr = 1'b1; end
            EXC_TYPE_ADES: begin exc_code = 5'h05; exc_addr = 1'b1; end
            EXC_TYPE_SYS:  exc_code = 5'h08;
            EXC_TYPE_BP:   exc_code = 5'h09;
            EXC_TYPE_RI:   exc_code = 5'h0a;
            EXC_TYPE_OV:   exc_code = 5'h0c;
            default:       exc_code = 5'h00;
        endcase
        is_eret    = (except_type == EXC_TYPE_ERET);
        exc_commit = (except_type != EXC_TYPE_NOEXC) && !is_eret;
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        tick_q, tick_d;

    // Half-rate Count; TI is sticky until Compare is rewritten (that clear wins)
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        tick_d    = ~tick_q;
        if (tick_q) count_d = count_q + 32'd1;
        if (we && waddr == 5'd9) begin
            count_d = wdata;
            tick_d  = 1'b0;
        end
        ti_d = ti_q | (count_d == compare_q);
        if (we && waddr == 5'd11) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
`else
    assign ti_q      = 1'b0;
    assign ti_d      = 1'b0;
    assign count_o   = '0;
    assign compare_o = '0;
`endif

    // Next state: MTC0 first, then exception/ERET overrides the fields it owns
    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        if (we) begin
            case (waddr)
                5'd12: begin
                    im_d  = wdata[15:8];
                    exl_d = wdata[1];
                    ie_d  = wdata[0];
                end
                5'd13:   ip_sw_d = wdata[9:8];
                5'd14:   epc_d   = wdata;
                default: ;
            endcase
        end
        if (exc_commit) begin
            if (!exl_q) begin
                epc_d = is_in_delayslotM ? (pcM - 32'd4) : pcM;
                bd_d  = is_in_delayslotM;
            end
            exl_d     = 1'b1;
            exccode_d = exc_code;
            if (exc_addr) badvaddr_d = badvaddrM;
        end else if (is_eret) begin
            exl_d = 1'b0;
        end
        ip_hw_d = {int_i[5] | ti_d, int_i[4:0]};
    end

    // Status/Cause/EPC/BadVAddr registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign status_o    = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_o     = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = ti_q;

    // MFC0 read mux from current register state
    always_comb begin
        case (raddr)
            5'd8:    rdata = badvaddr_o;
            5'd9:    rdata = count_o;
            5'd11:   rdata = compare_o;
            5'd12:   rdata = status_o;
            5'd13:   rdata = cause_o;
            5'd14:   rdata = epc_o;
            default: rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed test-plan checks plus randomized stimulus against a
// register-image reference model of cp0_regs. Honors CP0_TIMER_EN like the DUT.
`timescale 1ns/1ps
module tb_cp0_regs;
    localparam logic [31:0] NOEXC = 32'h0, INT = 32'h1, ADEL = 32'h4, ADES = 32'h5;
    localparam logic [31:0] SYS = 32'h8, BP = 32'h9, RI = 32'ha, OV = 32'hc, ERET = 32'he;

    logic        clk = 1'b0;
    logic        resetn;
    logic        we;
    logic [4:0]  waddr, raddr;
    logic [31:0] wdata, rdata, except_type, pcM, badvaddrM;
    logic        is_in_delayslotM;
    logic [5:0]  int_i;
    logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    cp0_regs dut (
        .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .except_type(except_type), .pcM(pcM),
        .is_in_delayslotM(is_in_delayslotM), .badvaddrM(badvaddrM), .int_i(int_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
        .count_o(count_o), .compare_o(compare_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: full architectural register images
    logic [31:0] m_status, m_cause, m_epc, m_bva, m_count, m_compare;
    logic        m_tog, m_ti;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_cause = '0; m_epc = '0; m_bva = '0; m_count = '0; m_compare = '0;
        m_tog = 1'b0; m_ti = 1'b0;
    endtask

    function automatic logic [4:0] code_of(input logic [31:0] t);
        case (t)
            ADEL: return 5'h04;
            ADES: return 5'h05;
            SYS:  return 5'h08;
            BP:   return 5'h09;
            RI:   return 5'h0a;
            OV:   return 5'h0c;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // Apply one clock edge worth of architectural rules to the model
    task automatic model_step();
        logic [31:0] st, ca, ep, bv, cn, cm;
        logic tg, ti;
        st = m_status; ca = m_cause; ep = m_epc; bv = m_bva;
        cn = m_count; cm = m_compare; tg = m_tog; ti = m_ti;
        if (we && waddr == 5'd12) st = 32'h0040_0000 | (wdata & 32'h0000_FF03);
        if (we && waddr == 5'd13) ca = (ca & ~32'h0000_0300) | (wdata & 32'h0000_0300);
        if (we && waddr == 5'd14) ep = wdata;
`ifdef CP0_TIMER_EN
        if (we && waddr == 5'd9) begin
            cn = wdata; tg = 1'b0;
        end else begin
            if (m_tog) cn = m_count + 32'd1;
            tg = !m_tog;
        end
        if (we && waddr == 5'd11) begin
            cm = wdata; ti = 1'b0;
        end else if (cn == m_compare) begin
            ti = 1'b1;
        end
`endif
        if (except_type != NOEXC && except_type != ERET) begin
            if (!m_status[1]) begin
                ep = is_in_delayslotM ? pcM - 32'd4 : pcM;
                ca[31] = is_in_delayslotM;
            end
            st[1] = 1'b1;
            ca[6:2] = code_of(except_type);
            if (except_type == ADEL || except_type == ADES) bv = badvaddrM;
        end else if (except_type == ERET) begin
            st[1] = 1'b0;
        end
        ca[30] = ti;
        ca[15] = int_i[5] | ti;
        ca[14:10] = int_i[4:0];
        m_status = st; m_cause = ca; m_epc = ep; m_bva = bv;
        m_count = cn; m_compare = cm; m_tog = tg; m_ti = ti;
    endtask

    task automatic check_all(input string where);
        check32({where, ".status"}, status_o, m_status);
        check32({where, ".cause"}, cause_o, m_cause);
        check32({where, ".epc"}, epc_o, m_epc);
        check32({where, ".badvaddr"}, badvaddr_o, m_bva);
        check32({where, ".count"}, count_o, m_count);
        check32({where, ".compare"}, compare_o, m_compare);
        check32({where, ".timer_int"}, 32'(timer_int_o), 32'(m_ti));
        check32({where, ".rdata"}, rdata, model_rd(raddr));
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [31:0] et, input logic [31:0] pc,
                         input logic ds, input logic [31:0] bad, input logic [5:0] ii);
        we = w; waddr = wa; wdata = wd; raddr = ra; except_type = et;
        pcM = pc; is_in_delayslotM = ds; badvaddrM = bad; int_i = ii;
    endtask

    task automatic step(input string where);
        @(posedge clk);
        model_step();
        #1;
        check_all(where);
    endtask

    logic [31:0] exc_list [8] = '{INT, ADEL, ADES, SYS, BP, RI, OV, ERET};

    initial begin
        logic [4:0] wa, ra;
        logic [31:0] wd, et;
        int unsigned pick;

        resetn = 1'b0;
        drive(0, 0, 0, 5'd12, NOEXC, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check32("reset.status_const", status_o, 32'h0040_0000);
        check32("reset.rd12", rdata, 32'h0040_0000);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_all("release");

        // SYS, not in delay slot, EXL=0
        drive(0, 0, 0, 5'd14, SYS, 32'hBFC0_1000, 0, 0, 0);
        step("sys");
        check32("sys.epc", epc_o, 32'hBFC0_1000);
        check32("sys.exccode", 32'(cause_o[6:2]), 32'h08);
        check32("sys.bd", 32'(cause_o[31]), 32'h0);
        check32("sys.exl", 32'(status_o[1]), 32'h1);

        drive(0, 0, 0, 5'd12, ERET, 0, 0, 0, 0);
        step("eret");
        check32("eret.exl", 32'(status_o[1]), 32'h0);

        // ADEL in delay slot, then RI while EXL=1
        drive(0, 0, 0, 5'd8, ADEL, 32'hBFC0_2004, 1, 32'h3, 0);
        step("adel");
        check32("adel.epc", epc_o, 32'hBFC0_2000);
        check32("adel.bd", 32'(cause_o[31]), 32'h1);
        check32("adel.badvaddr", badvaddr_o, 32'h3);
        drive(0, 0, 0, 5'd13, RI, 32'h0000_1234, 0, 32'h55, 0);
        step("ri");
        check32("ri.epc", epc_o, 32'hBFC0_2000);
        check32("ri.exccode", 32'(cause_o[6:2]), 32'h0a);
        check32("ri.badvaddr", badvaddr_o, 32'h3);

        // MTC0 Status with ERET in the same cycle
        drive(1, 5'd12, 32'h0000_0101, 5'd12, ERET, 0, 0, 0, 0);
        step("mtc0_eret");
        check32("mtc0_eret.status", status_o, 32'h0040_0101);

        // Interrupt line latency and software IP bits
        drive(0, 0, 0, 5'd13, NOEXC, 0, 0, 0, 6'b000001);
        #1;
        check32("int.before", 32'(cause_o[10]), 32'h0);
        step("int");
        check32("int.ip2", 32'(cause_o[10]), 32'h1);
        drive(1, 5'd13, 32'h0000_0300, 5'd13, NOEXC, 0, 0, 0, 6'b000001);
        step("cause_wr");
        check32("cause_wr.ipsw", 32'(cause_o[9:8]), 32'h3);
        check32("cause_wr.ip2", 32'(cause_o[10]), 32'h1);
        drive(0, 0, 0, 5'd13, NOEXC, 0, 0, 0, 6'b000000);
        step("int_drop");
        check32("int_drop.ip2", 32'(cause_o[10]), 32'h0);
        check32("int_drop.ipsw", 32'(cause_o[9:8]), 32'h3);

`ifdef CP0_TIMER_EN
        drive(1, 5'd11, 32'd5, 5'd11, NOEXC, 0, 0, 0, 0);
        step("cmp_wr");
        drive(1, 5'd9, 32'd0, 5'd9, NOEXC, 0, 0, 0, 0);
        step("cnt_wr");
        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 5'd9, NOEXC, 0, 0, 0, 0);
            step("timer");
            check32("timer.ti", 32'(timer_int_o), (k == 10) ? 32'h1 : 32'h0);
        end
        check32("timer.ip7", 32'(cause_o[15]), 32'h1);
        check32("timer.count", count_o, 32'd5);
        drive(1, 5'd11, 32'h0000_1000, 5'd13, NOEXC, 0, 0, 0, 0);
        step("ti_clr");
        check32("ti_clr.ti", 32'(timer_int_o), 32'h0);
        check32("ti_clr.ip7", 32'(cause_o[15]), 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0: wa = 5'd8;
                1: wa = 5'd9;
                2: wa = 5'd11;
                3: wa = 5'd12;
                4: wa = 5'd13;
                5: wa = 5'd14;
                default: wa = 5'($urandom_range(0, 31));
            endcase
            wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(8, 14)) : 5'($urandom_range(0, 31));
            et = ($urandom_range(0, 99) < 60) ? NOEXC : exc_list[$urandom_range(0, 7)];
            drive(1'($urandom_range(0, 1)), wa, wd, ra, et, $urandom(),
                  1'($urandom_range(0, 1)), $urandom(), 6'($urandom_range(0, 63)));
            #1;
            check32("rand.rdata_comb", rdata, model_rd(raddr));
            step("rand");
            if (i == 300) begin
                #2 resetn = 1'b0;
                #1 model_reset();
                check_all("async_reset");
                #1 resetn = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cp0_regs.md
# cp0_regs

Coprocessor-0 register file for the MIPS pipeline, sitting directly downstream of the MEM-stage exception-detection unit. It consumes the prioritised exception type, faulting PC and bad address each cycle and commits exception state (EXL, EPC, Cause, BadVAddr). It also services MTC0/MFC0 accesses and runs the Count/Compare timer. Its Status, Cause and EPC outputs feed back into exception detection and interrupt recognition.

## Interface
Parameters:
- none

Ports:
- clk  input  1  core clock; all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- we  input  1  MTC0 write enable (MEM/WB commit point)
- waddr  input  5  MTC0 destination register number
- wdata  input  32  MTC0 write data
- raddr  input  5  MFC0 source register number
- rdata  output  32  MFC0 read data, combinational from current register state
- except_type  input  32  prioritised exception type using the EXC_TYPE_* encodings from defines.vh
- pcM  input  32  PC of the instruction in MEM
- is_in_delayslotM  input  1  MEM instruction is in a branch delay slot
- badvaddrM  input  32  faulting address for address-error exceptions
- int_i  input  6  hardware interrupt lines, level sensitive
- status_o  output  32  Status (reg 12)
- cause_o  output  32  Cause (reg 13)
- epc_o  output  32  EPC (reg 14)
- badvaddr_o  output  32  BadVAddr (reg 8)
- count_o  output  32  Count (reg 9)
- compare_o  output  32  Compare (reg 11)
- timer_int_o  output  1  timer interrupt pending (Cause.TI)

## Operation
- Implemented registers: BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13), EPC (14). Reads of any other number return 0.
- Status:
  - BEV (bit 22) is hardwired to 1.
  - Writable bits: IM[15:8], EXL[1], IE[0]. All other bits read 0.
- Cause:
  - BD[31] and TI[30] are hardware-owned.
  - IP[15:10] are hardware-owned. Each cycle they load {int_i[5] | TI, int_i[4:0]}.
  - IP[9:8] are software-writable.
  - ExcCode[6:2] is hardware-owned. All other bits read 0.
- EPC and Compare are fully writable. BadVAddr is read-only to software.
- Exception commit applies when except_type is neither NOEXC nor ERET.
  - ExcCode mapping: INT→0x00, ADEL→0x04, ADES→0x05, SYS→0x08, BP→0x09, RI→0x0a, OV→0x0c.
  - If Status.EXL is 0: EPC ← is_in_delayslotM ? pcM−4 : pcM, and Cause.BD ← is_in_delayslotM.
  - If Status.EXL is already 1: EPC and BD are left unchanged.
  - Always: Status.EXL ← 1 and ExcCode is updated.
  - ADEL and ADES additionally set BadVAddr ← badvaddrM.
- ERET: Status.EXL ← 0. No other register changes.
- Priority within one cycle:
  - Exception or ERET update beats an MTC0 to the same field.
  - MTC0 to a non-conflicting register in the same cycle still takes effect.
- Timer: Count increments by 1 every second clk cycle, using an internal toggle bit, and wraps from 0xFFFF_FFFF to 0.
  - MTC0 to Count loads wdata and clears the toggle bit.
  - TI sets when Count == Compare, evaluated after the Count update.
  - MTC0 to Compare clears TI. That clear wins over a same-cycle match.

## Timing
- All writes are visible on outputs and rdata in the cycle after the edge that commits them. There is no write-to-read bypass.
- int_i reaches Cause.IP one cycle after sampling.
- Reset values:
  - Status = 0x0040_0000.
  - Cause, EPC, BadVAddr, Count and Compare = 0; toggle bit = 0; timer_int_o = 0.
  - rdata follows raddr from these values.
- Reset asserted mid-operation clears all state immediately, independent of clk.

## Configuration
- CP0_TIMER_EN defined: Count, Compare, the toggle bit and TI behave as described above.
- CP0_TIMER_EN undefined:
  - Count and Compare are removed. Reads of 9 and 11 return 0, and writes to them are ignored.
  - TI and timer_int_o are tied to 0, and Cause.IP[15] equals int_i[5].

## Test plan
- Reset release: Status = 0x0040_0000, all other outputs 0. Read raddr=12 → 0x0040_0000.
- except_type=SYS, pcM=0xBFC0_1000, not in a delay slot, EXL=0 → next cycle EPC=0xBFC0_1000, Cause[6:2]=0x08, BD=0, EXL=1.
- ADEL with is_in_delayslotM=1, pcM=0xBFC0_2004, badvaddrM=0x0000_0003 → EPC=0xBFC0_2000, BD=1, BadVAddr=0x0000_0003. A following RI while EXL=1 leaves EPC unchanged and sets ExcCode=0x0a.
- MTC0 Status=0x0000_0101 in the same cycle as ERET with EXL=1 → IM0=1, IE=1, EXL=0.
- (CP0_TIMER_EN) Write Compare=5, then Count=0 → timer_int_o rises 10 cycles after the Count write and Cause.IP[15]=1. A Compare write clears it the next cycle.
- int_i=6'b000001 held → Cause[10]=1 one cycle later. A Cause write with wdata=0x300 sets IP[9:8] and leaves IP[15:10] tracking int_i.
